// File: rtl/board_pkg.sv
// Shared board geometry, match-request record and cell-address helper used by
// the block remover / clearer pipeline.
package board_pkg;
  localparam int BOARD_COLS = 6;
  localparam int BOARD_ROWS = 12;
  localparam int COLOR_W    = 6;
  localparam logic [COLOR_W-1:0] COLOR_EMPTY = '0;

  typedef struct packed {
    logic [2:0] x;
    logic [3:0] y;
    logic [2:0] num;
    logic       dir;
  } remove_req_t;

  typedef struct packed {
    logic       en;
    logic [2:0] x;
    logic [3:0] y;
  } cell_t;

  typedef enum logic [1:0] {S_IDLE, S_FLASH, S_ERASE, S_DONE} clr_state_t;

  function automatic logic req_valid(input logic [2:0] num);
    return (num >= 3'd3) && (num <= 3'd5);
  endfunction

  // Cell i of a run; sums are one bit wider so off-board cells are detected, not wrapped.
  function automatic cell_t cell_at(input remove_req_t r, input logic [2:0] i);
    cell_t      c;
    logic [3:0] cx;
    logic [4:0] cy;
    cx   = {1'b0, r.x} + (r.dir ? 4'd0 : {1'b0, i});
    cy   = {1'b0, r.y} + (r.dir ? {2'b00, i} : 5'd0);
    c.en = (cx < 4'(BOARD_COLS)) && (cy < 5'(BOARD_ROWS));
    c.x  = c.en ? cx[2:0] : 3'd0;
    c.y  = c.en ? cy[3:0] : 4'd0;
    return c;
  endfunction
endpackage

// File: rtl/req_fifo.sv
// Small request queue with a combinational "contains" probe for duplicate filtering.
module req_fifo
  import board_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  remove_req_t din,
  input  remove_req_t probe,
  output remove_req_t head,
  output logic        empty,
  output logic        full,
  output logic        contains
);
  localparam int AW = $clog2(DEPTH);

  remove_req_t   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, off;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_comb begin
    contains = 1'b0;
    off      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr;
      if (({1'b0, off} < count) && (mem[i] == probe)) contains = 1'b1;
    end
  end
endmodule

// File: rtl/block_clearer.sv
// Queues unique match reports, flashes each run, erases it cell by cell and
// reports completion with the score increment.
module block_clearer
  import board_pkg::*;
#(
  parameter int FLASH_CYCLES    = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int SCORE_PER_BLOCK = 10
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [2:0]   removeX,
  input  logic [3:0]   removeY,
  input  logic [2:0]   removeNum,
  input  logic         removeDir,
  input  logic         flush,
  output logic         wrEn,
  output logic [2:0]   wrX,
  output logic [3:0]   wrY,
  output logic [5:0]   wrData,
  output logic         flash_active,
  output logic [2:0]   flashX,
  output logic [3:0]   flashY,
  output logic [2:0]   flashNum,
  output logic         flashDir,
  output logic         busy,
  output logic         clear_done,
  output logic [7:0]   score_add,
  output logic         drop_err
);
  localparam int FCW = $clog2(FLASH_CYCLES + 1);

  clr_state_t  state;
  remove_req_t req, active, last, head;
  logic        last_valid, dup, push, pop, empty, full, in_fifo;
  logic [FCW-1:0] fcnt;
  logic [2:0]  idx;
  cell_t       next_cell;

  assign req  = {removeX, removeY, removeNum, removeDir};
  assign dup  = ((state != S_IDLE) && (req == active)) || in_fifo ||
                (last_valid && (req == last));
  assign push = req_valid(removeNum) && !dup;
  assign pop  = (state == S_IDLE) && !empty;
  assign busy = (state != S_IDLE) || !empty;

  assign wrData   = COLOR_EMPTY;
  assign flashX   = active.x;
  assign flashY   = active.y;
  assign flashNum = active.num;
  assign flashDir = active.dir;

  // Address for the write issued in the coming cycle: cell 0 on FLASH exit, else idx+1.
  assign next_cell = cell_at(active, (state == S_FLASH) ? 3'd0 : idx + 3'd1);

  req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(Clk), .rst_n(Reset), .push(push), .pop(pop), .din(req), .probe(req),
    .head(head), .empty(empty), .full(full), .contains(in_fifo)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state        <= S_IDLE;
      active       <= '0;
      last         <= '0;
      last_valid   <= 1'b0;
      fcnt         <= '0;
      idx          <= '0;
      wrEn         <= 1'b0;
      wrX          <= '0;
      wrY          <= '0;
      flash_active <= 1'b0;
      clear_done   <= 1'b0;
      score_add    <= '0;
      drop_err     <= 1'b0;
    end else begin
      drop_err <= push && full && !pop;
      if (flush) last_valid <= 1'b0;
      case (state)
        S_IDLE: if (!empty) begin
          active       <= head;
          fcnt         <= '0;
          flash_active <= 1'b1;
          state        <= S_FLASH;
        end
        S_FLASH: if (fcnt == FCW'(FLASH_CYCLES - 1)) begin
          idx   <= '0;
          wrEn  <= next_cell.en;
          wrX   <= next_cell.x;
          wrY   <= next_cell.y;
          state <= S_ERASE;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
        S_ERASE: if (idx == active.num - 3'd1) begin
          wrEn         <= 1'b0;
          wrX          <= '0;
          wrY          <= '0;
          flash_active <= 1'b0;
          clear_done   <= 1'b1;
          score_add    <= 8'(active.num * SCORE_PER_BLOCK);
          state        <= S_DONE;
        end else begin
          idx  <= idx + 3'd1;
          wrEn <= next_cell.en;
          wrX  <= next_cell.x;
          wrY  <= next_cell.y;
        end
        S_DONE: begin
          // Record write takes priority over a coincident flush.
          last       <= active;
          last_valid <= 1'b1;
          clear_done <= 1'b0;
          score_add  <= '0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/block_clearer.md
Name: block_clearer

Overview:
- Downstream consumer of the block remover's match reports (removeX/removeY/removeNum/removeDir).
- Queues unique match requests, flashes each matched run for a fixed time, then erases its cells one per cycle through the board write port.
- Pulses completion so the gravity stage can re-settle, and reports the score increment.
- Board is 6 columns (x 0..5) × 12 rows (y 0..11); colour 6 bits, 0 = empty.

Parameters:
- FLASH_CYCLES, 32, number of cycles a run is highlighted before erase (≥1).
- FIFO_DEPTH, 4, request queue depth (power of two).
- SCORE_PER_BLOCK, 10, score units per erased block.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-low reset.
- removeX  in  3  start column of the reported run.
- removeY  in  4  start row of the reported run.
- removeNum  in  3  run length; 3..5 is a valid request, any other value means no request.
- removeDir  in  1  1 = vertical (y increments), 0 = horizontal (x increments).
- flush  in  1  forget the last-completed record (driven by just_swapped | just_shifted).
- wrEn  out  1  board write strobe.
- wrX  out  3  board write column.
- wrY  out  4  board write row.
- wrData  out  6  board write colour; always 0.
- flash_active  out  1  renderer highlight enable.
- flashX  out  3  renderer highlight start column.
- flashY  out  4  renderer highlight start row.
- flashNum  out  3  renderer highlight length.
- flashDir  out  1  renderer highlight direction.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- clear_done  out  1  one-cycle pulse after a run is fully erased.
- score_add  out  8  valid only while clear_done = 1; equals flashNum*SCORE_PER_BLOCK; 0 otherwise.
- drop_err  out  1  one-cycle pulse when a unique request is lost because the FIFO is full.

Behaviour:
- Reset (Reset = 0 at a Clk edge):
  - FSM to IDLE; FIFO emptied; last-completed record invalidated.
  - All outputs 0, including wrEn, busy, clear_done, score_add and drop_err.
  - Reset mid-operation abandons the run; wrEn is 0 from the next cycle.
- Request acceptance: each cycle, a request {X,Y,Num,Dir} with Num in 3..5 is pushed unless it equals any of:
  - the active run,
  - any FIFO entry,
  - the valid last-completed record.
  - Duplicates are dropped silently; the remover rescans continuously and repeats matches.
- FIFO full:
  - A unique request is dropped and drop_err pulses.
  - Exception: if a pop happens in the same cycle, the push is accepted.
- FSM:
  - IDLE: if the FIFO is non-empty, pop the head into the active run and go to FLASH. flash_active = 1 from the next cycle.
  - FLASH: hold for exactly FLASH_CYCLES cycles, then go to ERASE. flash_* outputs show the active run throughout.
  - ERASE: for i = 0..Num-1, one cell per cycle:
    - wrEn = 1, wrData = 0, cell = (X+i, Y) if Dir = 0, or (X, Y+i) if Dir = 1.
    - Cells with x > 5 or y > 11 are skipped: wrEn = 0 for that cycle, but the cycle is still spent.
    - ERASE always lasts Num cycles.
    - flash_active stays 1 during ERASE.
  - DONE (1 cycle):
    - clear_done = 1 and score_add = Num*SCORE_PER_BLOCK, counting all Num blocks including clipped ones.
    - Active run is copied to the last-completed record.
    - flash_active = 0; next state IDLE.
- Latency, request to first write: push edge, +1 cycle IDLE pop, +FLASH_CYCLES. Back-to-back queued runs insert one IDLE cycle between DONE and the next FLASH.
- flush:
  - Invalidates only the last-completed record.
  - Does not affect the FIFO or the active run.
  - If flush coincides with DONE, DONE's record write wins.
- Arithmetic: coordinate sums are computed 1 bit wider before the bounds check, so no wrap-around.

Decomposition:
- Shared package (board_pkg):
  - constants BOARD_COLS = 6, BOARD_ROWS = 12, COLOR_W = 6, COLOR_EMPTY = 0;
  - typedef struct remove_req_t {x[2:0], y[3:0], num[2:0], dir}.
  - The remover is later retyped against the same package.
- Sub-module: req_fifo (parameterised FIFO_DEPTH of remove_req_t, with a combinational "contains" match output used for dedup). The FSM, counters and write-address generation stay in the top.

Test Plan:
- Horizontal run: req X=1, Y=3, Num=3, Dir=0 held 100 cycles, FLASH_CYCLES=4 -> flash_active for 7 cycles; writes (1,3), (2,3), (3,3) with wrData = 0; exactly one clear_done with score_add = 30; no second run.
- Vertical run with clip: X=2, Y=10, Num=4, Dir=1 -> writes (2,10), (2,11) only; 2 idle ERASE cycles; score_add = 40.
- Queue and overflow: 6 distinct valid requests on consecutive cycles while busy -> first 5 accepted (1 active + 4 queued); 6th pulses drop_err; 5 clear_done pulses, in order.
- Dedup and flush: after completing (0,0,3,0), re-present it -> ignored; assert flush, re-present -> processed again.
- Invalid lengths: removeNum = 0, 2, 6 -> no push; busy stays 0.
- Reset mid-ERASE: Reset = 0 for 1 cycle after the 2nd write -> wrEn = 0 and busy = 0 next cycle; no clear_done.
